// File: rtl/cond_logic_if.sv
// ----------------------------------------------------------------------------
// cond_logic_if
// Bundles the instruction handshake, the decoded control inputs and the gated
// write-enable outputs of cond_logic.
//   master : instruction source (drives instr_valid + controls, sees results)
//   slave  : cond_logic itself
//
// Handshake: an instruction transfers at a rising edge where instr_valid and
// instr_ready are both 1. The source holds instr_valid and every control
// field stable until that edge. instr_ready never depends on instr_valid.
// ----------------------------------------------------------------------------
interface cond_logic_if;
    logic       instr_valid;
    logic       instr_ready;
    logic       CondEx;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic [3:0] Flags;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       commit;

    modport master (
        output instr_valid, CondEx, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        input  instr_ready, Flags, PCSrc, RegWrite, MemWrite, commit
    );

    modport slave (
        input  instr_valid, CondEx, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        output instr_ready, Flags, PCSrc, RegWrite, MemWrite, commit
    );
endinterface

// File: rtl/cond_logic.sv
// ----------------------------------------------------------------------------
// cond_logic
// Conditional-execution write gating with the architectural NZCV register.
// An accepted instruction's controls are latched, then during one COMMIT
// cycle the PC/register/memory write enables are driven gated by CondEx, and
// the flags selected by FlagW are loaded at the edge that ends COMMIT.
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous, active-high reset
//   bus       : cond_logic_if.slave (handshake, controls, gated outputs)
//   state_dbg : current FSM state (0 = IDLE, 1 = COMMIT)
// ----------------------------------------------------------------------------
module cond_logic (
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus,
    output logic         state_dbg
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;

    // Controls captured at accept and replayed during COMMIT.
    logic       cond_q,   cond_d;
    logic [3:0] alu_q,    alu_d;
    logic [1:0] flagw_q,  flagw_d;
    logic       pcs_q,    pcs_d;
    logic       regw_q,   regw_d;
    logic       memw_q,   memw_d;
    logic       nowr_q,   nowr_d;

    logic       accept;

    // ------------------------------------------------------------------
    // State register. Reset wins over everything, so a COMMIT interrupted
    // by reset never reaches the flag register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            flags_q <= 4'b0000;
            cond_q  <= 1'b0;
            alu_q   <= 4'b0000;
            flagw_q <= 2'b00;
            pcs_q   <= 1'b0;
            regw_q  <= 1'b0;
            memw_q  <= 1'b0;
            nowr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cond_q  <= cond_d;
            alu_q   <= alu_d;
            flagw_q <= flagw_d;
            pcs_q   <= pcs_d;
            regw_q  <= regw_d;
            memw_q  <= memw_d;
            nowr_q  <= nowr_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state, capture and flag update.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        cond_d  = cond_q;
        alu_d   = alu_q;
        flagw_d = flagw_q;
        pcs_d   = pcs_q;
        regw_d  = regw_q;
        memw_d  = memw_q;
        nowr_d  = nowr_q;
        accept  = bus.instr_valid && (state_q == ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_COMMIT;
                    cond_d  = bus.CondEx;
                    alu_d   = bus.ALUFlags;
                    flagw_d = bus.FlagW;
                    pcs_d   = bus.PCS;
                    regw_d  = bus.RegW;
                    memw_d  = bus.MemW;
                    nowr_d  = bus.NoWrite;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                // FlagW[1] owns N,Z and FlagW[0] owns C,V; a failed
                // condition leaves every flag untouched.
                if (cond_q) begin
                    if (flagw_q[1]) flags_d[3:2] = alu_q[3:2];
                    if (flagw_q[0]) flags_d[1:0] = alu_q[1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: pure decode of the current state and latched controls.
    // ------------------------------------------------------------------
    always_comb begin
        bus.instr_ready = (state_q == ST_IDLE);
        bus.commit      = (state_q == ST_COMMIT);
        bus.Flags       = flags_q;
        bus.PCSrc       = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemWrite    = 1'b0;
        if (state_q == ST_COMMIT) begin
            bus.PCSrc    = pcs_q  & cond_q;
            bus.RegWrite = regw_q & cond_q & ~nowr_q;
            bus.MemWrite = memw_q & cond_q;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_cond_logic.sv
module tb_cond_logic;

    typedef struct packed {
        logic       cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       nowr;
    } instr_t;

    logic clk;
    logic reset;
    logic state_dbg;
    int   n_checks;
    int   n_errors;
    bit   chk_en;

    cond_logic_if bus ();

    cond_logic dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // An instruction in flight sits in pend[] for exactly one cycle; while
    // it is there nothing new may enter. Flags follow the update rules.
    instr_t     pend[$];
    logic [3:0] m_flags;
    int         m_acc_cnt;

    initial begin
        m_flags   = 4'b0000;
        m_acc_cnt = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_flags = 4'b0000;
                pend.delete();
            end else if (pend.size() > 0) begin
                instr_t d;
                d = pend.pop_front();
                if (d.cond) begin
                    if (d.fw[1]) m_flags[3:2] = d.alu[3:2];
                    if (d.fw[0]) m_flags[1:0] = d.alu[1:0];
                end
            end else if (bus.instr_valid) begin
                pend.push_back(cur_instr());
                m_acc_cnt++;
            end
        end
    end

    function automatic instr_t cur_instr();
        instr_t t;
        t.cond = bus.CondEx;  t.alu  = bus.ALUFlags; t.fw = bus.FlagW;
        t.pcs  = bus.PCS;     t.regw = bus.RegW;     t.memw = bus.MemW;
        t.nowr = bus.NoWrite;
        return t;
    endfunction

    function automatic instr_t mk(input logic cond, input logic [3:0] alu,
                                  input logic [1:0] fw, input logic pcs,
                                  input logic regw, input logic memw,
                                  input logic nowr);
        instr_t t;
        t.cond = cond; t.alu = alu; t.fw = fw; t.pcs = pcs;
        t.regw = regw; t.memw = memw; t.nowr = nowr;
        return t;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle scoreboard against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic e_ready, e_commit, e_pc, e_rw, e_mw;
                e_ready = 1'b1; e_commit = 1'b0;
                e_pc = 1'b0; e_rw = 1'b0; e_mw = 1'b0;
                if (pend.size() > 0) begin
                    e_ready  = 1'b0;
                    e_commit = 1'b1;
                    e_pc = pend[0].pcs  & pend[0].cond;
                    e_rw = pend[0].regw & pend[0].cond & ~pend[0].nowr;
                    e_mw = pend[0].memw & pend[0].cond;
                end
                check("instr_ready", {3'b0, bus.instr_ready}, {3'b0, e_ready});
                check("commit",      {3'b0, bus.commit},      {3'b0, e_commit});
                check("state_dbg",   {3'b0, state_dbg},       {3'b0, e_commit});
                check("PCSrc",       {3'b0, bus.PCSrc},       {3'b0, e_pc});
                check("RegWrite",    {3'b0, bus.RegWrite},    {3'b0, e_rw});
                check("MemWrite",    {3'b0, bus.MemWrite},    {3'b0, e_mw});
                check("Flags",       bus.Flags,               m_flags);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input instr_t t, input logic valid);
        bus.instr_valid = valid;
        bus.CondEx = t.cond; bus.ALUFlags = t.alu; bus.FlagW = t.fw;
        bus.PCS = t.pcs; bus.RegW = t.regw; bus.MemW = t.memw;
        bus.NoWrite = t.nowr;
    endtask

    function automatic instr_t rnd_instr();
        return instr_t'($urandom_range(0, 1023));
    endfunction

    // Present an instruction and hold it until accepted; returns #1 after
    // the accepting edge (first cycle of COMMIT).
    task automatic send(input instr_t t);
        int start;
        bit ok;
        start = m_acc_cnt;
        ok = 1'b0;
        drive(t, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (m_acc_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 4 cycles at %0t", $time);
        end
        // Scramble the bus so only latched values can drive COMMIT.
        drive(rnd_instr(), 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        n_checks = 0;
        n_errors = 0;
        chk_en   = 1'b0;
        reset    = 1'b1;
        drive(instr_t'(0), 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_flags", bus.Flags, 4'b0000);
        check("rst_ready", {3'b0, bus.instr_ready}, 4'h1);
        check("rst_wen", {1'b0, bus.PCSrc, bus.RegWrite, bus.MemWrite}, 4'h0);

        // Full flag write with register write
        send(mk(1'b1, 4'b1010, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        check("t1_regwrite", {3'b0, bus.RegWrite}, 4'h1);
        check("t1_commit",   {3'b0, bus.commit},   4'h1);
        @(negedge clk);
        check("t1_flags", bus.Flags, 4'b1010);
        check("t1_ready", {3'b0, bus.instr_ready}, 4'h1);

        // C,V only
        send(mk(1'b1, 4'b0101, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        check("t2_flags", bus.Flags, 4'b1001);

        // Condition failed
        send(mk(1'b0, 4'b0110, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0));
        @(negedge clk);
        check("t3_pcsrc",    {3'b0, bus.PCSrc},    4'h0);
        check("t3_memwrite", {3'b0, bus.MemWrite}, 4'h0);
        @(negedge clk);
        check("t3_flags", bus.Flags, 4'b1001);

        // Compare-class instruction
        send(mk(1'b1, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1));
        @(negedge clk);
        check("t4_regwrite", {3'b0, bus.RegWrite}, 4'h0);
        @(negedge clk);
        check("t4_flags", bus.Flags, 4'b0100);

        // instr_valid held for 4 cycles: only alternate edges accept
        drive(mk(1'b0, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.commit) cnt++;
        end
        drive(instr_t'(0), 1'b0);
        check("hold_commits", cnt[3:0], 4'd2);
        check("hold_flags", bus.Flags, 4'b0100);

        // Reset during COMMIT
        send(mk(1'b1, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0));
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_flags", bus.Flags, 4'b0000);
        check("abort_wen", {bus.commit, bus.PCSrc, bus.RegWrite, bus.MemWrite}, 4'h0);
        check("abort_ready", {3'b0, bus.instr_ready}, 4'h1);

        // instr_valid together with reset is dropped
        @(posedge clk);
        #1;
        drive(mk(1'b1, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        drive(instr_t'(0), 1'b0);
        @(negedge clk);
        check("rstvalid_commit", {3'b0, bus.commit}, 4'h0);

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            drive(rnd_instr(), ($urandom_range(0, 3) != 0));
            reset = ($urandom_range(0, 49) == 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(instr_t'(0), 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
